// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of the unified-memory arbiter.
// The arbiter uses the master view; the core and the memory use the slave view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              if_stall;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic              dm_stall;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_done, if_stall, if_rdata,
        input  dm_req, dm_wr, dm_addr, dm_wdata,
        output dm_done, dm_stall, dm_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_done, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_stall, if_rdata,
        output dm_req, dm_wr, dm_addr, dm_wdata,
        input  dm_done, dm_stall, dm_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory: data priority with a
// bounded run of data grants, one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_DM_RUN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [RUN_W-1:0]  run_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wr_q;

    logic grant_dm, grant_if;
    logic mem_req, if_done, dm_done;

    // Fetch only wins a contended cycle once data has used up its run.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (bus.dm_req && !(bus.if_req && (run_cnt_q == RUN_MAX))) begin
                grant_dm = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_dm || grant_if) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completion pulse outside WAIT is stale and must not produce a done.
    always_comb begin
        mem_req = (state_q == ISSUE);
        if_done = bus.mem_done && (state_q == WAIT) && (owner_q == OWN_IF) && bus.if_req;
        dm_done = bus.mem_done && (state_q == WAIT) && (owner_q == OWN_DM);
    end

    // Request attributes are captured at grant so the memory sees stable values
    // even if a fetch is withdrawn or a data request drops mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the captured bus and run counter are reset so the memory never sees X after reset.
        if (!rst_n) begin
            owner_q     <= OWN_IF;
            run_cnt_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
        end else if (grant_dm) begin
            owner_q     <= OWN_DM;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_wr_q    <= bus.dm_wr;
            if (!bus.if_req) begin
                run_cnt_q <= '0;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_q <= run_cnt_q + 1'b1;
            end
        end else if (grant_if) begin
            owner_q    <= OWN_IF;
            mem_addr_q <= bus.if_addr;
            mem_wr_q   <= 1'b0;
            run_cnt_q  <= '0;
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.if_done   = if_done;
    assign bus.dm_done   = dm_done;
    assign bus.if_stall  = bus.if_req && !if_done;
    assign bus.dm_stall  = bus.dm_req && !dm_done;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_mem_arbiter;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MAX_DM_RUN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_DM_RUN(MAX_DM_RUN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // ---------------- memory model (latency lat cycles after mem_req) ----------------
    int lat = 1;
    logic stray = 1'b0;
    logic pend_done = 1'b0;
    logic [DATA_W-1:0] rdata_q = '0;
    logic [DATA_W-1:0] ram [logic [ADDR_W-1:0]];

    assign bus.mem_done  = pend_done | stray;
    assign bus.mem_rdata = rdata_q;

    initial begin
        int pend;
        logic seen_req, seen_wr;
        logic [ADDR_W-1:0] seen_addr, mem_a;
        logic [DATA_W-1:0] seen_wdata;
        pend = 0;
        mem_a = '0;
        forever begin
            @(negedge clk);
            seen_req   = bus.mem_req;
            seen_wr    = bus.mem_wr;
            seen_addr  = bus.mem_addr;
            seen_wdata = bus.mem_wdata;
            @(posedge clk);
            #1;
            pend_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (seen_req) begin
                mem_a = seen_addr;
                if (seen_wr) ram[seen_addr] = seen_wdata;
                pend = lat;
            end
            if (pend > 0) begin
                pend--;
                pend_done = (pend == 0);
            end
            rdata_q = ram.exists(mem_a) ? ram[mem_a] : init_word(mem_a);
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef enum {G_IF, G_DM} grant_e;
    grant_e grants[$];
    logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];

    initial begin
        bit busy;
        int age, run;
        grant_e t_own;
        logic [ADDR_W-1:0] t_addr;
        logic [DATA_W-1:0] t_wdata, exp_word;
        logic t_wr, exp_req, in_wait, exp_if_done, exp_dm_done;
        busy = 0; age = 0; run = 0;
        t_own = G_IF; t_addr = '0; t_wdata = '0; t_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0; run = 0; t_addr = '0; t_wr = 1'b0;
                check("rst mem_req",   bus.mem_req,   0);
                check("rst if_done",   bus.if_done,   0);
                check("rst dm_done",   bus.dm_done,   0);
                check("rst mem_addr",  bus.mem_addr,  0);
                check("rst mem_wr",    bus.mem_wr,    0);
                check("rst mem_wdata", bus.mem_wdata, 0);
                check("rst if_stall",  bus.if_stall,  bus.if_req);
                check("rst dm_stall",  bus.dm_stall,  bus.dm_req);
            end else begin
                exp_req     = busy && (age == 1);
                in_wait     = busy && (age >= 2);
                exp_if_done = in_wait && bus.mem_done && (t_own == G_IF) && bus.if_req;
                exp_dm_done = in_wait && bus.mem_done && (t_own == G_DM);
                exp_word    = shadow.exists(t_addr) ? shadow[t_addr] : init_word(t_addr);
                check("model mem_req",  bus.mem_req,  exp_req);
                check("model if_done",  bus.if_done,  exp_if_done);
                check("model dm_done",  bus.dm_done,  exp_dm_done);
                check("model if_stall", bus.if_stall, bus.if_req && !exp_if_done);
                check("model dm_stall", bus.dm_stall, bus.dm_req && !exp_dm_done);
                check("model mem_addr", bus.mem_addr, t_addr);
                check("model mem_wr",   bus.mem_wr,   t_wr);
                if (exp_req && t_wr) begin
                    check("model mem_wdata", bus.mem_wdata, t_wdata);
                    shadow[t_addr] = t_wdata;
                end
                if (exp_if_done) check("model if_rdata", bus.if_rdata, exp_word);
                if (exp_dm_done && !t_wr) check("model dm_rdata", bus.dm_rdata, exp_word);

                if (busy) begin
                    if (in_wait && bus.mem_done) busy = 0;
                    else age++;
                end else if (bus.if_req || bus.dm_req) begin
                    if (bus.dm_req && !(bus.if_req && run == MAX_DM_RUN)) begin
                        t_own = G_DM; t_addr = bus.dm_addr; t_wr = bus.dm_wr; t_wdata = bus.dm_wdata;
                        run = bus.if_req ? ((run < MAX_DM_RUN) ? run + 1 : MAX_DM_RUN) : 0;
                    end else begin
                        t_own = G_IF; t_addr = bus.if_addr; t_wr = 1'b0;
                        run = 0;
                    end
                    busy = 1; age = 1;
                    grants.push_back(t_own);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic wr_seq[$];
        bit exp_wr[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        grant_e exp_g[6] = '{G_DM, G_DM, G_IF, G_DM, G_DM, G_IF};
        logic got_if, got_dm;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        sample();
        check("reset mem_req", bus.mem_req, 0);
        check("reset if_stall", bus.if_stall, 0);
        step();
        rst_n = 1'b1;
        step();

        // single fetch, latency 1
        lat = 1; bus.if_req = 1'b1; bus.if_addr = 16'h0040;
        sample();
        check("fetch c0 if_stall", bus.if_stall, 1);
        check("fetch c0 mem_req", bus.mem_req, 0);
        step(); sample();
        check("fetch c1 mem_req", bus.mem_req, 1);
        check("fetch c1 mem_addr", bus.mem_addr, 16'h0040);
        check("fetch c1 mem_wr", bus.mem_wr, 0);
        check("fetch c1 if_stall", bus.if_stall, 1);
        step(); sample();
        check("fetch c2 if_done", bus.if_done, 1);
        check("fetch c2 if_rdata", bus.if_rdata, 16'hA583);
        check("fetch c2 if_stall", bus.if_stall, 0);
        step(); bus.if_req = 1'b0; step();

        // contention: store wins, fetch follows
        bus.if_req = 1'b1; bus.if_addr = 16'h0042;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h1000; bus.dm_wdata = 16'hBEEF;
        sample();
        check("cont c0 dm_stall", bus.dm_stall, 1);
        step(); sample();
        check("cont c1 mem_req", bus.mem_req, 1);
        check("cont c1 mem_wr", bus.mem_wr, 1);
        check("cont c1 mem_addr", bus.mem_addr, 16'h1000);
        check("cont c1 mem_wdata", bus.mem_wdata, 16'hBEEF);
        step(); sample();
        check("cont c2 dm_done", bus.dm_done, 1);
        check("cont c2 if_stall", bus.if_stall, 1);
        step(); bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
        sample();
        check("cont c3 mem_req", bus.mem_req, 0);
        step(); sample();
        check("cont c4 mem_req", bus.mem_req, 1);
        check("cont c4 mem_addr", bus.mem_addr, 16'h0042);
        check("cont c4 mem_wr", bus.mem_wr, 0);
        step(); sample();
        check("cont c5 if_done", bus.if_done, 1);
        step(); bus.if_req = 1'b0; step();

        // starvation limit: stores continuously pending, fetch held
        grants.delete();
        bus.if_req = 1'b1; bus.if_addr = 16'h0100;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 16'h3000; bus.dm_wdata = 16'h1111;
        for (int c = 0; c < 60 && wr_seq.size() < 6; c++) begin
            sample();
            if (bus.mem_req) wr_seq.push_back(bus.mem_wr);
            got_if = bus.if_done;
            got_dm = bus.dm_done;
            step();
            if (got_dm) begin
                bus.dm_addr  = bus.dm_addr + 16'h1;
                bus.dm_wdata = bus.dm_wdata + 16'h1111;
            end
            if (got_if) bus.if_addr = bus.if_addr + 16'h1;
        end
        check("starve issue count", wr_seq.size(), 6);
        for (int i = 0; i < wr_seq.size() && i < 6; i++)
            check($sformatf("starve dut order %0d", i), wr_seq[i], exp_wr[i]);
        check("starve grant count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check($sformatf("starve model order %0d", i), grants[i], exp_g[i]);
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
        repeat (4) step();

        // fetch flush during a latency-4 access
        lat = 4; bus.if_req = 1'b1; bus.if_addr = 16'h0060;
        step(); sample();
        check("flush c1 mem_req", bus.mem_req, 1);
        step(); bus.if_req = 1'b0;
        sample();
        check("flush c2 if_stall", bus.if_stall, 0);
        step(); step(); step();
        sample();
        check("flush c5 if_done", bus.if_done, 0);
        check("flush c5 dm_done", bus.dm_done, 0);
        step();
        lat = 1; bus.if_req = 1'b1; bus.if_addr = 16'h0080;
        sample();
        check("flush c6 mem_req", bus.mem_req, 0);
        step(); sample();
        check("flush c7 mem_req", bus.mem_req, 1);
        check("flush c7 mem_addr", bus.mem_addr, 16'h0080);
        step(); sample();
        check("flush c8 if_done", bus.if_done, 1);
        check("flush c8 if_rdata", bus.if_rdata, 16'hA543);
        step(); bus.if_req = 1'b0; step();

        // reset in WAIT, then a fresh load
        lat = 4; bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h2000;
        step(); sample();
        check("rstw c1 mem_req", bus.mem_req, 1);
        step(); rst_n = 1'b0; #1;
        check("rstw mem_req", bus.mem_req, 0);
        check("rstw dm_done", bus.dm_done, 0);
        check("rstw if_done", bus.if_done, 0);
        check("rstw mem_addr", bus.mem_addr, 0);
        check("rstw dm_stall", bus.dm_stall, 1);
        step(); rst_n = 1'b1; lat = 1;
        sample();
        check("rstw r0 mem_req", bus.mem_req, 0);
        step(); sample();
        check("rstw r1 mem_req", bus.mem_req, 1);
        check("rstw r1 mem_addr", bus.mem_addr, 16'h2000);
        check("rstw r1 mem_wr", bus.mem_wr, 0);
        step(); sample();
        check("rstw r2 dm_done", bus.dm_done, 1);
        check("rstw r2 dm_rdata", bus.dm_rdata, 16'h85C3);
        step(); bus.dm_req = 1'b0; step();

        // stray completion in IDLE, then a load of the earlier store
        stray = 1'b1;
        sample();
        check("stray if_done", bus.if_done, 0);
        check("stray dm_done", bus.dm_done, 0);
        check("stray mem_req", bus.mem_req, 0);
        step(); stray = 1'b0;
        sample();
        check("stray next mem_req", bus.mem_req, 0);
        step();
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h1000;
        step(); sample();
        check("stray load mem_req", bus.mem_req, 1);
        step(); sample();
        check("stray load dm_done", bus.dm_done, 1);
        check("stray load dm_rdata", bus.dm_rdata, 16'hBEEF);
        step(); bus.dm_req = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported, multi-cycle unified memory between the fetch stage (instruction reads) and the memory stage (data loads and stores) of the pipelined core. It arbitrates between the two requesters, with data priority and an anti-starvation limit, and sequences one memory transaction at a time. It returns per-requester done and stall signals, which the pipeline control uses alongside the decode-stall and fetch-flush signals from hazard detection.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_DM_RUN, 2, consecutive data grants allowed while fetch waits (≥1)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until if_done or withdrawn
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_done  out  1  fetch access complete, if_rdata valid this cycle
- if_stall  out  1  fetch must hold (if_req & ~if_done)
- if_rdata  out  DATA_W  instruction word
- dm_req  in  1  data request, held until dm_done
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_done  out  1  data access complete
- dm_stall  out  1  dm_req & ~dm_done
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  one-cycle transaction start pulse to memory
- mem_wr  out  1  write enable, valid with mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_done  in  1  memory completion pulse, ≥1 cycle after mem_req
- mem_rdata  in  DATA_W  read data, valid with mem_done

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: arbitrate on the current cycle's requests. Go to ISSUE on any grant, else stay.
  - Only dm_req asserted: grant DM.
  - Only if_req asserted: grant IF.
  - Both asserted: grant DM unless run_cnt == MAX_DM_RUN, then grant IF.
- On grant, register owner, address, write enable and write data into mem_addr, mem_wr and mem_wdata. mem_wr = dm_wr for DM and 0 for IF.
- ISSUE: mem_req = 1 for exactly one cycle, then go to WAIT.
- WAIT: hold until mem_done, then go to IDLE. mem_done seen in any state other than WAIT is ignored.
- Completion:
  - if_done = mem_done & WAIT & owner==IF & if_req.
  - dm_done = mem_done & WAIT & owner==DM.
  - if_rdata and dm_rdata pass mem_rdata through and are don't-care when the matching done is low.
- Fetch withdrawal: if_req may drop mid-transaction (fetch flush). The memory access still completes, the data is discarded, and no if_done is produced. A new if_req at a different address waits for IDLE.
- Data requests are never cancelled. A store is committed once issued, even if dm_req drops.
- run_cnt (width clog2(MAX_DM_RUN+1)):
  - Increments on each DM grant made while if_req is high, saturating at MAX_DM_RUN.
  - Clears on an IF grant, or on a DM grant while if_req is low.
- Stall outputs are combinational. if_stall = if_req & ~if_done, and dm_stall likewise. A requester with no request never stalls.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE; owner, run_cnt, mem_addr, mem_wdata and mem_wr go to 0.
  - mem_req = 0, if_done = 0, dm_done = 0.
  - Stalls follow the inputs.
- Reset during WAIT abandons the transaction; the memory shares rst_n and resets too.
- Minimum latency with a 1-cycle memory:
  - Request in IDLE at cycle 0, mem_req at cycle 1, mem_done and done at cycle 2.
  - Total 3 cycles, of which the requester stalls for 2 (cycles 0–1).
- The earliest next grant is in the cycle after done, since IDLE is re-entered on cycle done+1.
- Simultaneous requests in IDLE are resolved in the same cycle. Exactly one owner is ever in flight.
- Memory latency L adds L−1 cycles in WAIT, with no upper bound.

## Test plan
- Single fetch: if_req=1, if_addr=0x0040, memory latency 1 -> mem_req at cycle 1 with mem_addr=0x0040 and mem_wr=0; if_done and if_rdata at cycle 2; if_stall=1 on cycles 0–1 only.
- Contention: if_req and dm_req (store, 0x1000 <- 0xBEEF) both asserted at cycle 0 -> DM granted first with mem_wr=1, mem_addr=0x1000, mem_wdata=0xBEEF; IF granted in the cycle after dm_done.
- Starvation: if_req held while dm_req stays continuously asserted, MAX_DM_RUN=2 -> grant order DM, DM, IF, DM, DM, IF; run_cnt never exceeds 2.
- Fetch flush: if_req dropped in WAIT, memory latency 4 -> mem_done arrives and if_done stays 0; a new if_req at 0x0080 is issued at IDLE+1.
- Reset mid-access: rst_n asserted in WAIT -> mem_req=0, if_done=0, dm_done=0 immediately; after release, a fresh dm_req load completes normally in 3 cycles.
- Stray mem_done in IDLE -> no done pulse and no state change.
